mdu_unit: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit with HI/LO registers. It is the

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu_if.sv | 27 ++
 rtl/mdu_div_step.sv | 28 ++
 rtl/mdu_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_mdu_unit.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op and FSM state encodings for the multiply/divide unit.
// Optional feature macro used by the unit: MDU_DIV_EN (builds the divider).
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/response handshake bundle between the EX stage and the MDU.
//   master (pipeline): drives in_valid, op, A, B, out_ready
//   slave  (mdu_unit): drives in_ready, out_valid, res_hi, res_lo, err
interface mdu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] res_hi;
  logic [DATA_WIDTH-1:0] res_lo;
  logic                  err;

  modport master (
    output in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, res_hi, res_lo, err
  );

  modport slave (
    input  in_valid, op, A, B, out_ready,
    output in_ready, out_valid, res_hi, res_lo, err
  );
endinterface

// File: rtl/mdu_div_step.sv
// mdu_div_step: combinational single-bit restoring division step.
//   rem, quot, divisor : current partial remainder, dividend/quotient shift
//                        register, divisor magnitude
//   rem_next, quot_next: values after shifting in quot's MSB and one trial
//                        subtraction; the quotient bit enters at quot_next[0]
module mdu_div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quot,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic [DATA_WIDTH-1:0] quot_next
);
  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;
  logic                fits;

  // rem < divisor always holds, so shifted < 2*divisor fits in W+1 bits and
  // a negative trial difference is flagged by its top bit alone.
  always_comb begin
    shifted   = {rem, quot[DATA_WIDTH-1]};
    diff      = shifted - {1'b0, divisor};
    fits      = ~diff[DATA_WIDTH];
    rem_next  = fits ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    quot_next = {quot[DATA_WIDTH-2:0], fits};
  end
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with architectural HI/LO.
//   MULT/MULTU: shift-add, one bit per cycle; DIV/DIVU: restoring, one bit
//   per cycle (only when MDU_DIV_EN is defined; otherwise DIV/DIVU return
//   err=1 with zero results after one cycle). MTHI/MTLO write HI/LO directly.
// Ports:
//   clk, rst  : clock (rising edge), synchronous active-high reset
//   flush     : abort any operation, discard result, HI/LO untouched
//   bus       : mdu_if.slave request/response handshake
//   hi, lo    : architectural HI/LO registers, written only at the output
//               handshake or by MTHI/MTLO
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  mdu_if.slave                  bus,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W = DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH);

  state_t         state, state_next;
  logic [CNT_W-1:0] count;
  logic [W-1:0]   acc_hi, acc_lo, operand;
  logic           neg_q;
  logic           short_path;
  logic           out_valid_q, err_q;
  logic [W-1:0]   res_hi_q, res_lo_q;

  logic           accept, step, finish, commit;
  logic           is_mul, is_div, signed_op, a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] prod_fix;

`ifdef MDU_DIV_EN
  logic           op_div, neg_r;
  logic [W-1:0]   div_rem, div_quot;
  logic [W-1:0]   q_fix, r_fix;

  mdu_div_step #(.DATA_WIDTH(W)) u_div_step (
    .rem      (acc_hi),
    .quot     (acc_lo),
    .divisor  (operand),
    .rem_next (div_rem),
    .quot_next(div_quot)
  );
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;
  assign bus.res_hi    = res_hi_q;
  assign bus.res_lo    = res_lo_q;

  // Operand decode and magnitudes
  always_comb begin
    is_mul    = (bus.op == MDU_MULT) || (bus.op == MDU_MULTU);
    is_div    = (bus.op == MDU_DIV)  || (bus.op == MDU_DIVU);
    signed_op = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
    a_neg     = signed_op & bus.A[W-1];
    b_neg     = signed_op & bus.B[W-1];
    a_mag     = a_neg ? (~bus.A + 1'b1) : bus.A;
    b_mag     = b_neg ? (~bus.B + 1'b1) : bus.B;
  end

  // Datapath combinational helpers
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? operand : {W{1'b0}})};
    prod_fix = neg_q ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
`ifdef MDU_DIV_EN
    q_fix    = neg_q ? (~acc_lo + 1'b1) : acc_lo;
    r_fix    = neg_r ? (~acc_hi + 1'b1) : acc_hi;
`endif
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // FSM next-state and control strobes; flush overrides everything
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    step         = 1'b0;
    finish       = 1'b0;
    commit       = 1'b0;
    bus.in_ready = (state == S_IDLE) && !flush;
    case (state)
      S_IDLE: begin
        if (bus.in_valid && !flush) begin
          accept = 1'b1;
          if (is_mul || is_div) state_next = S_CALC;
        end
      end
      S_CALC: begin
        if (count == LAST) begin
          finish     = 1'b1;
          state_next = S_DONE;
        end else begin
          step = 1'b1;
        end
      end
      S_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          commit     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (flush) begin
      state_next = S_IDLE;
      accept     = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      commit     = 1'b0;
    end
  end

  // Datapath, result and HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      operand     <= '0;
      neg_q       <= 1'b0;
      short_path  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
      hi          <= '0;
      lo          <= '0;
`ifdef MDU_DIV_EN
      op_div      <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      if (accept && is_mul) begin
        count      <= '0;
        acc_hi     <= '0;
        acc_lo     <= b_mag;
        operand    <= a_mag;
        neg_q      <= a_neg ^ b_neg;
        short_path <= 1'b0;
`ifdef MDU_DIV_EN
        op_div     <= 1'b0;
`endif
      end

      // Divide-by-zero and compiled-out divide enter CALC with the counter
      // already exhausted, so the next edge produces the result.
      if (accept && is_div) begin
`ifdef MDU_DIV_EN
        op_div <= 1'b1;
        if (bus.B == '0) begin
          short_path <= 1'b1;
          count      <= LAST;
          acc_hi     <= bus.A;
        end else begin
          short_path <= 1'b0;
          count      <= '0;
          acc_hi     <= '0;
          acc_lo     <= a_mag;
          operand    <= b_mag;
          neg_q      <= a_neg ^ b_neg;
          neg_r      <= a_neg;
        end
`else
        short_path <= 1'b1;
        count      <= LAST;
`endif
      end

      if (accept && (bus.op == MDU_MTHI)) hi <= bus.A;
      if (accept && (bus.op == MDU_MTLO)) lo <= bus.A;

      if (step) begin
        count <= count + 1'b1;
`ifdef MDU_DIV_EN
        if (op_div) begin
          acc_hi <= div_rem;
          acc_lo <= div_quot;
        end else
`endif
        begin
          acc_hi <= mul_sum[W:1];
          acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
        end
      end

      if (finish) begin
        out_valid_q <= 1'b1;
        if (short_path) begin
          err_q <= 1'b1;
`ifdef MDU_DIV_EN
          res_hi_q <= acc_hi;
          res_lo_q <= '1;
`else
          res_hi_q <= '0;
          res_lo_q <= '0;
`endif
        end else begin
          err_q <= 1'b0;
`ifdef MDU_DIV_EN
          if (op_div) begin
            res_hi_q <= r_fix;
            res_lo_q <= q_fix;
          end else
`endif
          begin
            res_hi_q <= prod_fix[2*W-1:W];
            res_lo_q <= prod_fix[W-1:0];
          end
        end
      end

      if (commit) begin
        hi          <= res_hi_q;
        lo          <= res_lo_q;
        out_valid_q <= 1'b0;
        err_q       <= 1'b0;
      end

      if (flush) begin
        out_valid_q <= 1'b0;
        err_q       <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mdu_unit.sv
module tb_mdu_unit;
  localparam int DW = 32;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [DW-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_if #(.DATA_WIDTH(DW)) bus ();

  mdu_unit #(.DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request; returns just after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.op       = op;
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    #0;
    check("in_ready_at_issue", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      lat++;
      if (bus.out_valid === 1'b1) break;
    end
    if (bus.out_valid !== 1'b1) check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
  endtask

  // Full op with out_ready=1: latency, result, then commit into HI/LO.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input int exp_lat, input logic exp_err,
                        input logic [DW-1:0] exp_hi, input logic [DW-1:0] exp_lo);
    int lat;
    bus.out_ready = 1'b1;
    issue(op, a, b);
    wait_done(lat);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_err"}, 64'(bus.err), 64'(exp_err));
    check({tag, "_res_hi"}, 64'(bus.res_hi), 64'(exp_hi));
    check({tag, "_res_lo"}, 64'(bus.res_lo), 64'(exp_lo));
    tick();
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    check({tag, "_out_valid_clr"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    bit seen;
    logic [DW-1:0] keep_hi, keep_lo;

    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = 3'b000; bus.A = '0; bus.B = '0;
    tick(); tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_res", {bus.res_hi, bus.res_lo}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    #0;
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // MULT -2*3 with consumer stalled
    issue(3'b000, 32'hFFFF_FFFE, 32'd3);
    wait_done(lat);
    check("mult_latency", 64'(lat), 64'd33);
    check("mult_res", {bus.res_hi, bus.res_lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    check("mult_err", 64'(bus.err), 64'd0);
    tick(); tick();
    check("mult_stall_valid", 64'(bus.out_valid), 64'd1);
    check("mult_stall_hilo", {hi, lo}, 64'd0);
    bus.out_ready = 1'b1;
    tick();
    check("mult_commit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    // MULTU max*max; HI/LO change only the edge after out_valid
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat);
    check("multu_res", {bus.res_hi, bus.res_lo}, 64'hFFFF_FFFE_0000_0001);
    check("multu_hi_before", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    tick();
    check("multu_commit", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run_op("mult_negneg", 3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 33, 1'b0, 32'h0, 32'hF);
    run_op("mult_posneg", 3'b000, 32'd7, 32'hFFFF_FFFC, 33, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFE4);

    // Divides
    run_op("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 33 : 1, !DIV_EN,
           DIV_EN ? 32'hFFFF_FFFF : 32'h0, DIV_EN ? 32'hFFFF_FFFD : 32'h0);
    run_op("divu_7_2", 3'b011, 32'd7, 32'd2, DIV_EN ? 33 : 1, !DIV_EN,
           DIV_EN ? 32'd1 : 32'h0, DIV_EN ? 32'd3 : 32'h0);
    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, DIV_EN ? 33 : 1, !DIV_EN,
           32'h0, DIV_EN ? 32'h8000_0000 : 32'h0);
    run_op("div_by0", 3'b010, 32'd5, 32'd0, 1, 1'b1,
           DIV_EN ? 32'd5 : 32'h0, DIV_EN ? 32'hFFFF_FFFF : 32'h0);
    keep_hi = DIV_EN ? 32'd5 : 32'h0;
    keep_lo = DIV_EN ? 32'hFFFF_FFFF : 32'h0;

    // Flush in the middle of CALC
    issue(3'b000, 32'd2, 32'd3);
    repeat (10) tick();
    flush = 1'b1;
    #0;
    check("flush_in_ready_low", 64'(bus.in_ready), 64'd0);
    tick();
    flush = 1'b0;
    #0;
    check("flush_calc_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check("flush_calc_no_valid", 64'(seen), 64'd0);
    check("flush_calc_hilo", {hi, lo}, {keep_hi, keep_lo});

    // Flush in DONE beats a simultaneous output handshake
    bus.out_ready = 1'b0;
    issue(3'b000, 32'd4, 32'd5);
    wait_done(lat);
    check("flush_done_res", {bus.res_hi, bus.res_lo}, 64'd20);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_done_valid", 64'(bus.out_valid), 64'd0);
    check("flush_done_err", 64'(bus.err), 64'd0);
    check("flush_done_hilo", {hi, lo}, {keep_hi, keep_lo});

    // MTHI then MULT back-to-back, consumer stalled 5 cycles
    bus.out_ready = 1'b0;
    issue(3'b100, 32'h1234, 32'd0);
    check("mthi_hi", 64'(hi), 64'h1234);
    issue(3'b000, 32'd2, 32'd3);
    wait_done(lat);
    check("b2b_latency", 64'(lat), 64'd33);
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.res_hi !== 32'h0 || bus.res_lo !== 32'd6 || hi !== 32'h1234)
        seen = 1'b1;
    end
    check("b2b_stall_stable", 64'(seen), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    check("b2b_commit", {hi, lo}, 64'h0000_0000_0000_0006);

    // Reset mid-CALC wins over flush
    issue(3'b001, 32'd9, 32'd9);
    repeat (5) tick();
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    #0;
    check("rst_calc_hilo", {hi, lo}, 64'd0);
    check("rst_calc_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (40) tick();
    check("rst_calc_no_valid", 64'(bus.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
